// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the pipelined RISC core.
// Holds one decoded instruction, stalls on load-use and forwards from EX/MEM and MEM/WB.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_valid,
    output logic          id_ready,
    input  logic [RW-1:0] id_rs_a,
    input  logic [RW-1:0] id_rs_b,
    input  logic [DW-1:0] id_rd_a,
    input  logic [DW-1:0] id_rd_b,
    input  logic [DW-1:0] id_imm,
    input  logic          id_use_imm,
    input  logic [3:0]    id_gselect,
    input  logic [RW-1:0] id_rd,
    input  logic          id_wr_en,
    input  logic          id_mem_rd,
    input  logic          flush,
    input  logic          ex_ready,
    input  logic          exm_wr_en,
    input  logic [RW-1:0] exm_rd,
    input  logic [DW-1:0] exm_result,
    input  logic          wb_wr_en,
    input  logic [RW-1:0] wb_rd,
    input  logic [DW-1:0] wb_data,
    output logic          ex_valid,
    output logic [DW-1:0] ex_A,
    output logic [DW-1:0] ex_B,
    output logic [3:0]    ex_gselect,
    output logic [RW-1:0] ex_rd,
    output logic          ex_wr_en,
    output logic          ex_mem_rd
);

    logic          valid_q, valid_d;
    logic [RW-1:0] rs_a_q, rs_a_d;
    logic [RW-1:0] rs_b_q, rs_b_d;
    logic [DW-1:0] opa_q, opa_d;
    logic [DW-1:0] opb_q, opb_d;
    logic [DW-1:0] imm_q, imm_d;
    logic          use_imm_q, use_imm_d;
    logic [3:0]    gsel_q, gsel_d;
    logic [RW-1:0] rd_q, rd_d;
    logic          wr_en_q, wr_en_d;
    logic          mem_rd_q, mem_rd_d;

    logic          adv;
    logic          haz;
    logic          ld_dst;
    logic [DW-1:0] cap_a;
    logic [DW-1:0] cap_b;
    logic [DW-1:0] fwd_a;
    logic [DW-1:0] fwd_b;

    // Advance/stall decision: a held load blocks a consumer for one cycle.
    always_comb begin
        adv    = ex_ready | ~valid_q;
        ld_dst = valid_q & mem_rd_q & wr_en_q & (rd_q != '0);
        haz    = id_valid & ld_dst
               & ((rd_q == id_rs_a)
               | (~id_use_imm & (rd_q == id_rs_b)));
        id_ready = adv & ~haz;
    end

    // Operand capture: r0 reads zero, a same-cycle write-back wins over the regfile.
    always_comb begin
        cap_a = id_rd_a;
        cap_b = id_rd_b;
        if (id_rs_a == '0) begin
            cap_a = '0;
        end else if (wb_wr_en && (wb_rd != '0) && (wb_rd == id_rs_a)) begin
            cap_a = wb_data;
        end
        if (id_rs_b == '0) begin
            cap_b = '0;
        end else if (wb_wr_en && (wb_rd != '0) && (wb_rd == id_rs_b)) begin
            cap_b = wb_data;
        end
    end

    // Next-state: flush beats bubble beats capture beats hold.
    always_comb begin
        valid_d   = valid_q;
        rs_a_d    = rs_a_q;
        rs_b_d    = rs_b_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        imm_d     = imm_q;
        use_imm_d = use_imm_q;
        gsel_d    = gsel_q;
        rd_d      = rd_q;
        wr_en_d   = wr_en_q;
        mem_rd_d  = mem_rd_q;
        if (flush) begin
            valid_d  = 1'b0;
            wr_en_d  = 1'b0;
            mem_rd_d = 1'b0;
        end else if (adv && haz) begin
            valid_d  = 1'b0;
            wr_en_d  = 1'b0;
            mem_rd_d = 1'b0;
            gsel_d   = '0;
        end else if (adv) begin
            valid_d   = id_valid;
            rs_a_d    = id_rs_a;
            rs_b_d    = id_rs_b;
            opa_d     = cap_a;
            opb_d     = cap_b;
            imm_d     = id_imm;
            use_imm_d = id_use_imm;
            gsel_d    = id_gselect;
            rd_d      = id_rd;
            wr_en_d   = id_wr_en & id_valid;
            mem_rd_d  = id_mem_rd & id_valid;
        end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rs_a_q    <= '0;
            rs_b_q    <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            gsel_q    <= '0;
            rd_q      <= '0;
            wr_en_q   <= 1'b0;
            mem_rd_q  <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            rs_a_q    <= rs_a_d;
            rs_b_q    <= rs_b_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            imm_q     <= imm_d;
            use_imm_q <= use_imm_d;
            gsel_q    <= gsel_d;
            rd_q      <= rd_d;
            wr_en_q   <= wr_en_d;
            mem_rd_q  <= mem_rd_d;
        end
    end

    // Forwarding: the younger EX/MEM result shadows MEM/WB; r0 never forwards.
    always_comb begin
        fwd_a = opa_q;
        fwd_b = opb_q;
        if (exm_wr_en && (exm_rd != '0) && (exm_rd == rs_a_q)) begin
            fwd_a = exm_result;
        end else if (wb_wr_en && (wb_rd != '0) && (wb_rd == rs_a_q)) begin
            fwd_a = wb_data;
        end
        if (exm_wr_en && (exm_rd != '0) && (exm_rd == rs_b_q)) begin
            fwd_b = exm_result;
        end else if (wb_wr_en && (wb_rd != '0) && (wb_rd == rs_b_q)) begin
            fwd_b = wb_data;
        end
    end

    // Output drive: the immediate bypasses forwarding entirely.
    always_comb begin
        ex_valid   = valid_q;
        ex_A       = fwd_a;
        ex_B       = use_imm_q ? imm_q : fwd_b;
        ex_gselect = gsel_q;
        ex_rd      = rd_q;
        ex_wr_en   = wr_en_q;
        ex_mem_rd  = mem_rd_q;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard cases then random traffic.
// Accepted instructions are queued; a monitor compares the stage output each cycle.
`timescale 1ns/1ps
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_ready;
    logic [4:0]  id_rs_a, id_rs_b;
    logic [31:0] id_rd_a, id_rd_b, id_imm;
    logic        id_use_imm;
    logic [3:0]  id_gselect;
    logic [4:0]  id_rd;
    logic        id_wr_en, id_mem_rd;
    logic        flush, ex_ready;
    logic        exm_wr_en;
    logic [4:0]  exm_rd;
    logic [31:0] exm_result;
    logic        wb_wr_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_A, ex_B;
    logic [3:0]  ex_gselect;
    logic [4:0]  ex_rd;
    logic        ex_wr_en, ex_mem_rd;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
        .id_rd_a(id_rd_a), .id_rd_b(id_rd_b),
        .id_imm(id_imm), .id_use_imm(id_use_imm),
        .id_gselect(id_gselect), .id_rd(id_rd),
        .id_wr_en(id_wr_en), .id_mem_rd(id_mem_rd),
        .flush(flush), .ex_ready(ex_ready),
        .exm_wr_en(exm_wr_en), .exm_rd(exm_rd), .exm_result(exm_result),
        .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B),
        .ex_gselect(ex_gselect), .ex_rd(ex_rd),
        .ex_wr_en(ex_wr_en), .ex_mem_rd(ex_mem_rd)
    );

    typedef struct {
        int unsigned cyc;
        logic [3:0]  gsel;
        logic [4:0]  rd;
        logic        wr_en;
        logic        mem_rd;
        logic [4:0]  rs_a;
        logic [4:0]  rs_b;
        logic [31:0] va;
        logic [31:0] vb;
        logic [31:0] imm;
        logic        use_imm;
    } inst_t;

    inst_t       exp_q[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_err = 0;
    bit          acc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Architectural value of register rs as seen now, given its captured value.
    function automatic logic [31:0] newest(input logic [4:0] rs, input logic [31:0] v);
        if (rs == 0) return 32'h0;
        if (exm_wr_en && exm_rd == rs) return exm_result;
        if (wb_wr_en && wb_rd == rs) return wb_data;
        return v;
    endfunction

    task automatic next();
        @(negedge clk);
        cyc++;
    endtask

    task automatic late();
        #3;
    endtask

    task automatic set_id(input logic v, input logic [4:0] ra, input logic [4:0] rb,
                          input logic [31:0] da, input logic [31:0] db,
                          input logic [31:0] im, input logic ui, input logic [3:0] g,
                          input logic [4:0] rd, input logic we, input logic mr);
        id_valid = v; id_rs_a = ra; id_rs_b = rb; id_rd_a = da; id_rd_b = db;
        id_imm = im; id_use_imm = ui; id_gselect = g; id_rd = rd;
        id_wr_en = we; id_mem_rd = mr;
    endtask

    task automatic set_fwd(input logic xe, input logic [4:0] xr, input logic [31:0] xd,
                           input logic we, input logic [4:0] wr, input logic [31:0] wd);
        exm_wr_en = xe; exm_rd = xr; exm_result = xd;
        wb_wr_en = we; wb_rd = wr; wb_data = wd;
    endtask

    // Decide acceptance from the model, check id_ready, queue the accepted instruction.
    task automatic settle();
        inst_t e;
        bit cur, haz, rdy;
        #1;
        cur = exp_q.size() > 0 && exp_q[0].cyc < cyc;
        haz = 1'b0;
        if (cur && id_valid) begin
            e = exp_q[0];
            haz = e.mem_rd && e.wr_en && e.rd != 0 &&
                  (e.rd == id_rs_a || (!id_use_imm && e.rd == id_rs_b));
        end
        rdy = (!cur || ex_ready) && !haz;
        chk("id_ready", id_ready, rdy);
        acc = rst_n && id_valid && rdy && !flush;
        if (acc) begin
            e.cyc = cyc; e.gsel = id_gselect; e.rd = id_rd;
            e.wr_en = id_wr_en; e.mem_rd = id_mem_rd;
            e.rs_a = id_rs_a; e.rs_b = id_rs_b;
            e.imm = id_imm; e.use_imm = id_use_imm;
            e.va = (id_rs_a == 0) ? 32'h0 :
                   (wb_wr_en && wb_rd == id_rs_a) ? wb_data : id_rd_a;
            e.vb = (id_rs_b == 0) ? 32'h0 :
                   (wb_wr_en && wb_rd == id_rs_b) ? wb_data : id_rd_b;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: compare the stage output against the queued instruction every cycle.
    initial begin
        inst_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n) begin
                exp_q.delete();
                chk("rst ex_valid", ex_valid, 0);
                chk("rst ex_wr_en", ex_wr_en, 0);
                chk("rst ex_mem_rd", ex_mem_rd, 0);
                chk("rst ex_gselect", ex_gselect, 0);
                chk("rst ex_rd", ex_rd, 0);
                chk("rst ex_A", ex_A, 0);
                chk("rst ex_B", ex_B, 0);
            end else if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                e = exp_q[0];
                chk("ex_valid", ex_valid, 1);
                chk("ex_gselect", ex_gselect, e.gsel);
                chk("ex_rd", ex_rd, e.rd);
                chk("ex_wr_en", ex_wr_en, e.wr_en);
                chk("ex_mem_rd", ex_mem_rd, e.mem_rd);
                chk("ex_A", ex_A, newest(e.rs_a, e.va));
                chk("ex_B", ex_B, e.use_imm ? e.imm : newest(e.rs_b, e.vb));
                if (flush || ex_ready) void'(exp_q.pop_front());
            end else begin
                chk("idle ex_valid", ex_valid, 0);
                chk("idle ex_wr_en", ex_wr_en, 0);
                chk("idle ex_mem_rd", ex_mem_rd, 0);
            end
        end
    end

    initial begin
        bit hold;
        rst_n = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0);

        // reset, then idle
        repeat (2) begin next(); settle(); end
        next(); rst_n = 1'b1; settle();
        repeat (3) begin
            next(); settle(); late();
            chk("idle gselect", ex_gselect, 0);
            chk("idle id_ready", id_ready, 1);
        end

        // back-to-back ALU dependency through EX/MEM
        next(); set_id(1, 1, 2, 32'h11, 32'h22, 0, 0, 4'b0010, 3, 1, 0); settle();
        next(); set_id(1, 3, 1, 32'h99, 32'h11, 0, 0, 4'b1100, 4, 1, 0); settle();
        late(); chk("dep no stall", id_ready, 1);
        next(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(1, 3, 32'hFF, 0, 0, 0); settle(); late();
        chk("dep ex_A", ex_A, 32'hFF);
        chk("dep ex_B", ex_B, 32'h11);

        // load-use: one bubble, then MEM/WB supplies the load data
        next(); set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 1, 0, 32'h11, 0, 32'h10, 1, 4'b0000, 5, 1, 1); settle();
        next(); set_id(1, 5, 0, 0, 0, 1, 1, 4'b0001, 6, 1, 0); settle(); late();
        chk("lu stall", id_ready, 0);
        next(); settle(); late();
        chk("lu bubble", ex_valid, 0);
        chk("lu resume", id_ready, 1);
        next(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 1, 5, 32'h1234_5678); settle(); late();
        chk("lu ex_A", ex_A, 32'h1234_5678);
        chk("lu ex_valid", ex_valid, 1);

        // EX/MEM beats MEM/WB; r0 never forwards
        next(); set_fwd(0, 0, 0, 0, 0, 0);
        set_id(1, 7, 0, 32'h77, 0, 0, 0, 0, 1, 1, 0); settle();
        next(); set_id(1, 0, 0, 32'h55, 32'h66, 0, 0, 0, 2, 1, 0);
        set_fwd(1, 7, 32'hA, 1, 7, 32'hB); settle(); late();
        chk("prio ex_A", ex_A, 32'hA);
        next(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(1, 0, 32'hA, 1, 0, 32'hB); settle(); late();
        chk("r0 ex_A", ex_A, 0);
        chk("r0 ex_B", ex_B, 0);

        // write-through at capture
        next(); set_id(1, 0, 2, 0, 32'h1, 0, 0, 0, 3, 1, 0);
        set_fwd(0, 0, 0, 1, 2, 32'hCAFE); settle();
        next(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(0, 0, 0, 0, 0, 0); settle(); late();
        chk("wt ex_B", ex_B, 32'hCAFE);

        // stall, flush during stall, reset during stall
        next(); set_id(1, 4, 6, 32'h4444, 32'h6666, 0, 0, 4'b1001, 9, 1, 0); settle();
        repeat (3) begin
            next(); ex_ready = 1'b0;
            set_id(1, 3, 3, 32'h3, 32'h3, 0, 0, 4'b0100, 10, 1, 0); settle(); late();
            chk("stall id_ready", id_ready, 0);
            chk("stall ex_A", ex_A, 32'h4444);
            chk("stall ex_B", ex_B, 32'h6666);
            chk("stall ex_rd", ex_rd, 9);
        end
        next(); flush = 1'b1; settle();
        next(); flush = 1'b0; settle(); late();
        chk("flush ex_valid", ex_valid, 0);
        next(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); settle();
        #1; rst_n = 1'b0; exp_q.delete(); #2;
        chk("async rst ex_valid", ex_valid, 0);
        next(); settle();
        next(); rst_n = 1'b1; ex_ready = 1'b1; settle();

        // random traffic
        hold = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            next();
            flush = ($urandom_range(0, 19) == 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            set_fwd($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom);
            if (!hold) begin
                set_id($urandom_range(0, 9) < 7,
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       $urandom, $urandom, $urandom, $urandom_range(0, 1),
                       4'($urandom), 5'($urandom_range(0, 7)),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            end
            settle();
            hold = id_valid && !acc && !flush;
        end

        next(); set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b0; ex_ready = 1'b1; settle();
        next(); settle(); late();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register with operand forwarding and load-use hazard detection for the pipelined RISC CPU. It captures decoded instructions and register-file operands from the decode stage. It resolves data hazards from the EX/MEM and MEM/WB stages and presents the final A, B and 4-bit Gselect operands to the execute-stage ALU. The block uses a valid/ready handshake on both sides and supports flush for branch redirect.

## Interface
- DW, 32, datapath width
- RW, 5, register-address width; register 0 is hard-wired zero
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- id_valid  in  1  decode stage presents an instruction
- id_ready  out  1  stage accepts the decode instruction this cycle
- id_rs_a, id_rs_b  in  RW  source register addresses
- id_rd_a, id_rd_b  in  DW  register-file read data
- id_imm  in  DW  immediate
- id_use_imm  in  1  B operand is id_imm instead of rs_b
- id_gselect  in  4  ALU operation: 0xxx arithmetic, 1xxx logic
- id_rd  in  RW  destination register
- id_wr_en  in  1  instruction writes id_rd
- id_mem_rd  in  1  instruction is a load
- flush  in  1  kill the instruction held in the stage
- ex_ready  in  1  downstream accepts the stage output
- exm_wr_en, exm_rd, exm_result  in  1/RW/DW  EX/MEM write-back info (ALU result)
- wb_wr_en, wb_rd, wb_data  in  1/RW/DW  MEM/WB write-back info (final data)
- ex_valid  out  1  stage output valid
- ex_A, ex_B  out  DW  forwarded ALU operands
- ex_gselect  out  4  registered operation
- ex_rd, ex_wr_en, ex_mem_rd  out  RW/1/1  registered destination info

## Operation
- Load enable: `adv = ex_ready | ~ex_valid`.
- Load-use hazard: `haz = id_valid & ex_valid & ex_mem_rd & ex_wr_en & (ex_rd != 0) & ((ex_rd == id_rs_a) | (~id_use_imm & ex_rd == id_rs_b))`.
- `id_ready = adv & ~haz`. This is combinational.
- On the clock edge, evaluated in priority order:
  - flush: ex_valid<=0. Other registers are don't-care, but ex_wr_en<=0.
  - else if adv & haz: insert a bubble. ex_valid<=0, ex_wr_en<=0, ex_mem_rd<=0, ex_gselect<=0.
  - else if adv: ex_valid<=id_valid, and all id_* fields are captured.
  - else: hold all registers.
- Write-through at capture: if wb_wr_en & wb_rd != 0 & wb_rd == id_rs_x, capture wb_data instead of id_rd_x. This covers a register-file write and read in the same cycle.
- Captured rs = 0 always yields data 0.
- Forwarding is combinational on the registered sources, per operand x in {a, b}:
  - EX/MEM first: exm_wr_en & exm_rd != 0 & exm_rd == rs_x gives exm_result.
  - else MEM/WB: wb_wr_en & wb_rd != 0 & wb_rd == rs_x gives wb_data.
  - else the captured data.
- ex_A = fwd_a.
- ex_B = use_imm ? imm : fwd_b. No forwarding is applied when use_imm is set.
- Bubble or invalid output: ex_A and ex_B are don't-care. ex_wr_en and ex_mem_rd are guaranteed 0.

## Timing
- Reset (rst_n low, asynchronous): all registers clear to 0.
  - ex_valid=0, ex_gselect=0, ex_rd=0, ex_wr_en=0, ex_mem_rd=0.
  - ex_A=0 and ex_B=0, since rs=0 and imm=0 in reset state.
  - id_ready=1.
- Reset mid-operation discards the held instruction with no partial state.
- Latency: 1 cycle from an accepted id handshake to ex_valid. Forwarding adds no cycle.
- A load followed directly by a dependent instruction costs exactly 1 bubble. The dependent instruction then receives the load data via the MEM/WB path.
- Throughput is 1 instruction per cycle with no hazard and ex_ready=1.
- ex_ready=0 holds the outputs stable. Forwarded values may change only if upstream forwarding inputs change.
- flush together with id_valid: the decode instruction is not captured. id_ready may still read 1; the decode stage is flushed by the same signal.
- flush has priority over haz and over ex_ready=0.

## Test plan
- Reset then idle:
  - rst_n low for 2 cycles, then release with id_valid=0.
  - Required: ex_valid=0, ex_wr_en=0, ex_gselect=0, id_ready=1 throughout.
- Back-to-back ALU dependency:
  - Issue `r3=r1+r2` (gselect 0010), then `r4=r3^r1` (1100).
  - Drive exm_rd=3, exm_wr_en=1, exm_result=0x0000_00FF when the second instruction is in the stage.
  - Required: ex_A=0x0000_00FF and ex_B equals the r1 read data, with no stall.
- Load-use:
  - Issue a load to r5, then `r6=r5+1` (0001).
  - Required: id_ready=0 for exactly 1 cycle, then one bubble (ex_valid=0).
  - Then the dependent instruction with ex_A=wb_data=0x1234_5678 when wb_rd=5.
- Priority and r0:
  - exm_rd=wb_rd=7, both wr_en=1, exm_result=0xA, wb_data=0xB. Required: ex_A=0xA.
  - Repeat with rs=0 and both rd=0. Required: ex_A=0.
- Write-through at capture:
  - wb_wr_en=1, wb_rd=2, wb_data=0xCAFE, with id_rs_b=2 and stale id_rd_b=0x1 at acceptance.
  - Required: ex_B=0xCAFE after the MEM/WB inputs drop.
- Stall and flush:
  - Hold ex_ready=0 for 3 cycles. Required: outputs stable and id_ready=0.
  - Assert flush with ex_ready=0. Required: ex_valid=0 next cycle.
  - Assert rst_n low mid-stall. Required: ex_valid clears immediately.
